// File: rtl/read_retry_ctrl.sv
// Per-agent read controller: issues one RAM read, drops collided data and reissues
// after a staggered backoff, then returns data (or an exhaustion error) on a valid/ready channel.
module read_retry_ctrl #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 2,
  parameter int AGENT_ID       = 0,
  parameter int NB_RDAGENT     = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  rdreq_valid,
  output logic                  rdreq_ready,
  input  logic [ADDR_WIDTH-1:0] rdreq_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  m_rden,
  output logic [ADDR_WIDTH-1:0] m_rdaddr,
  input  logic [DATA_WIDTH-1:0] m_rddata,
  input  logic                  collision,
  output logic [CNT_WIDTH-1:0]  retry_total
);

  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BO_W = $clog2(BACKOFF_CYCLES + NB_RDAGENT + 1);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);
  localparam logic [BO_W-1:0] BO_INIT = BO_W'(BACKOFF_CYCLES + AGENT_ID);
  localparam logic [BO_W-1:0] BO_ONE  = BO_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    BACKOFF,
    RESP
  } state_t;

  state_t          state;
  logic [RC_W-1:0] retry_cnt;
  logic [BO_W-1:0] bo_cnt;

  // m_rden and rdreq_ready are set on the transition into ISSUE / IDLE so they
  // stay pure registers while still matching the state they belong to.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state       <= IDLE;
      rdreq_ready <= 1'b0;
      m_rden      <= 1'b0;
      m_rdaddr    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      retry_cnt   <= '0;
      bo_cnt      <= '0;
      retry_total <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rdreq_valid && rdreq_ready) begin
            m_rdaddr    <= rdreq_addr;
            retry_cnt   <= '0;
            rdreq_ready <= 1'b0;
            m_rden      <= 1'b1;
            state       <= ISSUE;
          end else begin
            rdreq_ready <= 1'b1;
          end
        end
        ISSUE: begin
          m_rden <= 1'b0;
          state  <= CHECK;
        end
        CHECK: begin
          if (!collision) begin
            rsp_data  <= m_rddata;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            if (retry_total != '1) begin
              retry_total <= retry_total + 1'b1;
            end
            if (retry_cnt == RC_MAX) begin
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              bo_cnt    <= BO_INIT;
              if (BO_INIT != '0) begin
                state <= BACKOFF;
              end else begin
                m_rden <= 1'b1;
                state  <= ISSUE;
              end
            end
          end
        end
        BACKOFF: begin
          bo_cnt <= bo_cnt - 1'b1;
          if (bo_cnt == BO_ONE) begin
            m_rden <= 1'b1;
            state  <= ISSUE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rdreq_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          m_rden      <= 1'b0;
          rsp_valid   <= 1'b0;
          rdreq_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_retry_ctrl.sv
// Bench for read_retry_ctrl: two instances (staggered backoff / zero backoff with a 2-bit counter)
// driven from a vector table, with a RAM/collision responder and a response scoreboard.
module tb_read_retry_ctrl;

  typedef struct {
    int          u;
    logic [7:0]  addr;
    logic [7:0]  pat;
    int          stall;
    logic [31:0] data;
    logic        err;
    int          issues;
    logic [15:0] tot;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [15:0] tot;
  } exp_t;

  logic        clk = 1'b0;
  logic        srst;
  logic        rdreq_valid [2];
  logic        rdreq_ready [2];
  logic [7:0]  rdreq_addr  [2];
  logic        rsp_valid   [2];
  logic        rsp_ready   [2];
  logic [31:0] rsp_data    [2];
  logic        rsp_err     [2];
  logic        m_rden      [2];
  logic [7:0]  m_rdaddr    [2];
  logic [31:0] m_rddata    [2];
  logic        collision   [2];
  logic [15:0] tot_a;
  logic [1:0]  tot_b;
  logic [15:0] tot [2];

  assign tot[0] = tot_a;
  assign tot[1] = {14'd0, tot_b};

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  pat [2];
  int          issue_n [2];
  logic        prev_rden [2];
  logic [7:0]  prev_addr [2];
  int          pulse_cyc [2][$];
  exp_t        sb [2][$];
  vec_t        vt [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  read_retry_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_RETRY(3), .BACKOFF_CYCLES(2),
    .AGENT_ID(1), .NB_RDAGENT(2), .CNT_WIDTH(16)
  ) dut_a (
    .aclk(clk), .srst(srst),
    .rdreq_valid(rdreq_valid[0]), .rdreq_ready(rdreq_ready[0]), .rdreq_addr(rdreq_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .m_rden(m_rden[0]), .m_rdaddr(m_rdaddr[0]), .m_rddata(m_rddata[0]), .collision(collision[0]),
    .retry_total(tot_a)
  );

  read_retry_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_RETRY(1), .BACKOFF_CYCLES(0),
    .AGENT_ID(0), .NB_RDAGENT(2), .CNT_WIDTH(2)
  ) dut_b (
    .aclk(clk), .srst(srst),
    .rdreq_valid(rdreq_valid[1]), .rdreq_ready(rdreq_ready[1]), .rdreq_addr(rdreq_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .m_rden(m_rden[1]), .m_rdaddr(m_rdaddr[1]), .m_rddata(m_rddata[1]), .collision(collision[1]),
    .retry_total(tot_b)
  );

  function automatic logic [31:0] rdval(input logic [7:0] a);
    return 32'hCAFE0000 + {24'd0, a} - 32'h0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM + collision responder: data/flag arrive one cycle after m_rden, junk otherwise.
  initial begin
    for (int u = 0; u < 2; u++) begin
      prev_rden[u] = 1'b0; prev_addr[u] = '0; issue_n[u] = 0; pat[u] = '0;
      collision[u] = 1'b0; m_rddata[u] = '0;
    end
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        if (prev_rden[u]) begin
          collision[u] = (issue_n[u] < 8) ? pat[u][issue_n[u]] : 1'b1;
          m_rddata[u]  = rdval(prev_addr[u]);
          issue_n[u]++;
        end else begin
          collision[u] = 1'($urandom_range(0, 1));
          m_rddata[u]  = $urandom;
        end
        if (m_rden[u] === 1'b1) pulse_cyc[u].push_back(cyc);
        prev_rden[u] = (m_rden[u] === 1'b1);
        prev_addr[u] = m_rdaddr[u];
      end
    end
  end

  // Scoreboard: compare on the cycle the handshake is about to happen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rsp_valid[u] === 1'b1 && rsp_ready[u] === 1'b1) begin
          if (sb[u].size() == 0) begin
            chk("sb_unexpected_rsp", 1, 0);
          end else begin
            e = sb[u].pop_front();
            chk("rsp_data", rsp_data[u], e.data);
            chk("rsp_err", rsp_err[u], e.err);
            chk("retry_total", tot[u], e.tot);
          end
        end
      end
    end
  end

  task automatic do_req(input vec_t v);
    int u, k, t1, sp;
    logic [31:0] held;
    exp_t e;
    u  = v.u;
    sp = (u == 0) ? 5 : 2;
    k  = 0;
    while (rdreq_ready[u] !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk("req_ready", rdreq_ready[u], 1);
    pat[u] = v.pat; issue_n[u] = 0; pulse_cyc[u].delete();
    e.data = v.data; e.err = v.err; e.tot = v.tot;
    sb[u].push_back(e);
    rdreq_addr[u] = v.addr; rdreq_valid[u] = 1'b1; rsp_ready[u] = (v.stall == 0);
    @(posedge clk); #1;
    rdreq_valid[u] = 1'b0;
    t1 = cyc;
    chk("m_rdaddr", m_rdaddr[u], v.addr);
    k = 0;
    while (rsp_valid[u] !== 1'b1 && k < 60) begin @(posedge clk); #1; k++; end
    chk("rsp_timeout", rsp_valid[u], 1);
    if (v.stall > 0) begin
      held = rsp_data[u];
      rdreq_addr[u] = ~v.addr; rdreq_valid[u] = 1'b1;
      for (int i = 0; i < v.stall; i++) begin
        chk("bp_valid", rsp_valid[u], 1);
        chk("bp_data", rsp_data[u], held);
        chk("bp_rdreq_ready", rdreq_ready[u], 0);
        chk("bp_rden", m_rden[u], 0);
        chk("bp_addr", m_rdaddr[u], v.addr);
        @(posedge clk); #1;
      end
      rsp_ready[u] = 1'b1;
    end
    @(posedge clk); #1;
    rdreq_valid[u] = 1'b0; rsp_ready[u] = 1'b0;
    chk("idle_ready", rdreq_ready[u], 1);
    chk("rsp_dropped", rsp_valid[u], 0);
    chk("issues", pulse_cyc[u].size(), v.issues);
    if (pulse_cyc[u].size() > 0) chk("first_issue_cycle", pulse_cyc[u][0], t1);
    for (int i = 1; i < pulse_cyc[u].size(); i++)
      chk("reissue_gap", pulse_cyc[u][i] - pulse_cyc[u][i-1], sp);
    chk("sb_drain", sb[u].size(), 0);
  endtask

  initial begin
    int t1;
    //        u  addr   pat    stall data          err  issues tot
    vt[0] = '{0, 8'h10, 8'h00, 0, 32'hCAFE0001, 1'b0, 1, 16'd0};
    vt[1] = '{0, 8'h20, 8'h01, 0, 32'hCAFE0011, 1'b0, 2, 16'd1};
    vt[2] = '{0, 8'h33, 8'hFF, 0, 32'h00000000, 1'b1, 4, 16'd5};
    vt[3] = '{0, 8'h44, 8'h00, 5, 32'hCAFE0035, 1'b0, 1, 16'd5};
    vt[4] = '{0, 8'h55, 8'h03, 0, 32'hCAFE0046, 1'b0, 3, 16'd7};
    vt[5] = '{1, 8'h18, 8'h01, 0, 32'hCAFE0009, 1'b0, 2, 16'd1};
    vt[6] = '{1, 8'h19, 8'h03, 0, 32'h00000000, 1'b1, 2, 16'd3};
    vt[7] = '{1, 8'h1A, 8'h03, 2, 32'h00000000, 1'b1, 2, 16'd3};

    srst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      rdreq_valid[u] = 1'b0; rdreq_addr[u] = '0; rsp_ready[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_rdreq_ready", rdreq_ready[u], 0);
      chk("rst_m_rden", m_rden[u], 0);
      chk("rst_rsp_valid", rsp_valid[u], 0);
      chk("rst_rsp_err", rsp_err[u], 0);
      chk("rst_rsp_data", rsp_data[u], 0);
      chk("rst_m_rdaddr", m_rdaddr[u], 0);
      chk("rst_retry_total", tot[u], 0);
    end
    srst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", rdreq_ready[0], 1);

    for (int i = 0; i < 8; i++) do_req(vt[i]);

    // Reset while unit 0 sits in BACKOFF after a collided first read.
    pat[0] = 8'hFF; issue_n[0] = 0; pulse_cyc[0].delete();
    rdreq_addr[0] = 8'h66; rdreq_valid[0] = 1'b1;
    @(posedge clk); #1;
    rdreq_valid[0] = 1'b0;
    t1 = cyc;
    while (cyc < t1 + 3) begin @(posedge clk); #1; end
    chk("pre_rst_issued", pulse_cyc[0].size(), 1);
    chk("pre_rst_backoff_rden", m_rden[0], 0);
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    chk("midrst_m_rden", m_rden[0], 0);
    chk("midrst_rsp_valid", rsp_valid[0], 0);
    chk("midrst_retry_total_a", tot[0], 0);
    chk("midrst_retry_total_b", tot[1], 0);
    chk("midrst_rdreq_ready", rdreq_ready[0], 0);
    pulse_cyc[0].delete();
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_reissue", pulse_cyc[0].size(), 0);
    chk("midrst_no_rsp", rsp_valid[0], 0);
    do_req('{0, 8'h10, 8'h00, 0, 32'hCAFE0001, 1'b0, 1, 16'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
